// File: rtl/display_test_pkg.sv
// Shared constants for the seven-segment display pattern generator.
// Build option: define PATTERN_BCD_EN to give mode 2 a decimal counter;
// without it mode 2 counts in hex exactly like mode 1.
package display_test_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [1:0] MODE_SHIFT = 2'd0;
    localparam logic [1:0] MODE_HEX   = 2'd1;
    localparam logic [1:0] MODE_BCD   = 2'd2;
    localparam logic [1:0] MODE_WALK  = 2'd3;

    typedef enum logic {
        ST_PAUSED  = 1'b0,
        ST_RUNNING = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/digit_counter.sv
// One nibble of the HEX/BCD ripple counter: computes the next nibble value
// and the carry into the next digit. Storage lives in the parent.
// Build option: PATTERN_BCD_EN compiles the decimal (9 -> 0) wrap logic.
module digit_counter
    import display_test_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_value,
    input  logic               i_inc,
    input  logic               i_clr,
    input  logic               i_bcd,
    output logic [DIGIT_W-1:0] o_value_c,
    output logic               o_carry_c
);

    logic w_max;

`ifdef PATTERN_BCD_EN
    // Digit is at its wrap point: 9 in decimal, F in hex
    always_comb begin
        w_max = i_bcd ? (i_value >= DIGIT_W'(9)) : (i_value == {DIGIT_W{1'b1}});
    end
`else
    logic w_unused_bcd;
    assign w_unused_bcd = i_bcd;

    // Digit is at its wrap point: hex only
    always_comb begin
        w_max = (i_value == {DIGIT_W{1'b1}});
    end
`endif

    // Next nibble and carry-out
    always_comb begin
        o_carry_c = i_inc & w_max;
        o_value_c = i_value;
        if (i_clr) begin
            o_value_c = '0;
        end else if (i_inc) begin
            o_value_c = w_max ? '0 : i_value + 1'b1;
        end
    end

endmodule

// File: rtl/display_pattern_gen.sv
// Stimulus generator for the seven-segment display interface: NDIG hex
// digits plus decimal points, advanced by a prescaled tick or single steps,
// in one of four patterns (SHIFT, HEX, BCD, WALK).
// Build option: PATTERN_BCD_EN enables decimal counting in mode 2; when
// undefined, mode 2 is a hex counter identical to mode 1.
module display_pattern_gen
    import display_test_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned TICK_DIV = 4194304
) (
    input  logic                    clk5,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    run,
    input  logic                    step,
    output logic [DIGIT_W*NDIG-1:0] dispVal,
    output logic [NDIG-1:0]         dpMask,
    output logic                    update
);

    localparam int unsigned DISP_W = DIGIT_W * NDIG;
    localparam int unsigned CNT_W  = NDIG + 3;
    localparam int unsigned PRE_W  = $clog2(TICK_DIV);
    localparam int unsigned POS_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0] DP_PAUSED = NDIG'(1) << (NDIG - 1);

    ctrl_state_e      r_state;
    logic [PRE_W-1:0] r_pre;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [POS_W-1:0] r_p;

    logic              w_tick;
    logic              w_mode_chg;
    logic              w_cnt_inc;
    logic              w_bcd;
    logic [NDIG:0]     w_inc;
    logic [DISP_W-1:0] w_cnt_val;
    logic              w_unused_carry;
    logic [CNT_W-1:0]  w_tick_cnt_n;
    logic [POS_W-1:0]  w_p_n;
    logic [DISP_W-1:0] w_disp_n;
    logic [NDIG-1:0]   w_dp_n;
    logic              w_load;

    // Tick source and mode-change detection; a mode change swallows a tick
    always_comb begin
        w_tick = ((r_state == ST_RUNNING) && (r_pre == PRE_W'(TICK_DIV - 1))) ||
                 ((r_state == ST_PAUSED) && step);
        w_mode_chg = (mode != r_mode);
        w_cnt_inc  = w_tick && !w_mode_chg && ((mode == MODE_HEX) || (mode == MODE_BCD));
`ifdef PATTERN_BCD_EN
        w_bcd = (mode == MODE_BCD);
`else
        w_bcd = 1'b0;
`endif
    end

    // HEX/BCD ripple chain; in counting modes dispVal itself holds the digits
    assign w_inc[0]       = w_cnt_inc;
    assign w_unused_carry = w_inc[NDIG];

    genvar g;
    for (g = 0; g < NDIG; g++) begin : g_digit
        digit_counter u_digit (
            .i_value   (dispVal[g*DIGIT_W +: DIGIT_W]),
            .i_inc     (w_inc[g]),
            .i_clr     (w_mode_chg),
            .i_bcd     (w_bcd),
            .o_value_c (w_cnt_val[g*DIGIT_W +: DIGIT_W]),
            .o_carry_c (w_inc[g+1])
        );
    end

    // Next pattern state, display value and decimal-point mask
    always_comb begin
        w_tick_cnt_n = r_tick_cnt;
        w_p_n        = r_p;
        w_disp_n     = dispVal;
        w_dp_n       = '0;
        if (w_mode_chg) begin
            w_tick_cnt_n = '0;
            w_p_n        = '0;
            w_disp_n     = '0;
        end else if (w_tick) begin
            case (mode)
                MODE_SHIFT: begin
                    w_tick_cnt_n = r_tick_cnt + 1'b1;
                    for (int k = 0; k < NDIG; k++) begin
                        w_disp_n[k*DIGIT_W +: DIGIT_W] = w_tick_cnt_n[k +: DIGIT_W];
                    end
                end
                MODE_WALK: begin
                    w_p_n = (r_p == POS_W'(NDIG - 1)) ? '0 : r_p + 1'b1;
                    for (int k = 0; k < NDIG; k++) begin
                        w_disp_n[k*DIGIT_W +: DIGIT_W] = (w_p_n == POS_W'(k)) ? 4'h8 : 4'h0;
                    end
                end
                default: begin
                    w_disp_n = w_cnt_val;
                end
            endcase
        end
        if (mode == MODE_WALK) begin
            for (int k = 0; k < NDIG; k++) begin
                w_dp_n[k] = (w_p_n == POS_W'(k));
            end
        end else begin
            w_dp_n[NDIG-1] = (r_state == ST_PAUSED);
        end
        w_load = w_mode_chg || w_tick || (w_dp_n != dpMask);
    end

    // Control FSM, prescaler, pattern state and registered outputs
    always_ff @(posedge clk5) begin
        if (reset) begin
            r_state    <= ST_PAUSED;
            r_pre      <= '0;
            r_mode     <= MODE_SHIFT;
            r_tick_cnt <= '0;
            r_p        <= '0;
            dispVal    <= '0;
            dpMask     <= DP_PAUSED;
            update     <= 1'b0;
        end else begin
            r_state <= run ? ST_RUNNING : ST_PAUSED;
            if (r_state == ST_RUNNING) begin
                r_pre <= (r_pre == PRE_W'(TICK_DIV - 1)) ? '0 : r_pre + 1'b1;
            end else begin
                r_pre <= '0;
            end
            r_mode     <= mode;
            r_tick_cnt <= w_tick_cnt_n;
            r_p        <= w_p_n;
            dispVal    <= w_disp_n;
            dpMask     <= w_dp_n;
            update     <= w_load;
        end
    end

endmodule

// File: tb/tb_display_pattern_gen.sv
// Self-checking bench for display_pattern_gen (NDIG=4, TICK_DIV=4) plus a
// small NDIG=2, TICK_DIV=2 instance used for the counter wrap.
module tb_display_pattern_gen;

    logic        clk5 = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        run;
    logic        step;
    logic [15:0] dispVal;
    logic [3:0]  dpMask;
    logic        update;

    logic [1:0]  mode2;
    logic        step2;
    logic        run2;
    logic [7:0]  dispVal2;
    logic [1:0]  dpMask2;
    logic        update2;

    int checks = 0;
    int passed = 0;
    int exp_hex = 0;

    always #100 clk5 = ~clk5;

    display_pattern_gen #(.NDIG(4), .TICK_DIV(4)) u_dut (
        .clk5(clk5), .reset(reset), .mode(mode), .run(run), .step(step),
        .dispVal(dispVal), .dpMask(dpMask), .update(update)
    );

    display_pattern_gen #(.NDIG(2), .TICK_DIV(2)) u_dut2 (
        .clk5(clk5), .reset(reset), .mode(mode2), .run(run2), .step(step2),
        .dispVal(dispVal2), .dpMask(dpMask2), .update(update2)
    );

    // Reference patterns computed from tick counts
    function automatic logic [15:0] shift_model(int n);
        int cnt = n % 128;
        int r = 0;
        for (int k = 0; k < 4; k++) r = r | (((cnt >> k) & 15) << (4 * k));
        return 16'(r);
    endfunction

    function automatic logic [15:0] dec_model(int n);
`ifdef PATTERN_BCD_EN
        int v = n % 10000;
        int r = 0;
        int p10 = 1;
        for (int k = 0; k < 4; k++) begin
            r = r | (((v / p10) % 10) << (4 * k));
            p10 = p10 * 10;
        end
        return 16'(r);
`else
        return 16'(n % 65536);
`endif
    endfunction

    function automatic logic [15:0] walk_model(int n);
        return 16'(8 << (4 * (n % 4)));
    endfunction

    task automatic cyc;
        @(posedge clk5);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (dispVal !== 16'h0000) $display("FAIL reset_disp got %h want %h", dispVal, 16'h0000); else passed++;
        checks++; if (dpMask !== 4'b1000) $display("FAIL reset_dp got %b want %b", dpMask, 4'b1000); else passed++;
        checks++; if (update !== 1'b0) $display("FAIL reset_upd got %b want 0", update); else passed++;
        checks++; if (dispVal2 !== 8'h00) $display("FAIL reset_disp2 got %h want 00", dispVal2); else passed++;
        checks++; if (dpMask2 !== 2'b10) $display("FAIL reset_dp2 got %b want 10", dpMask2); else passed++;
    endtask

    task automatic test_hex_run;
        int n_end;
        logic exp_upd;
        mode = 2'd1;
        cyc;
        checks++; if (update !== 1'b1) $display("FAIL hex_modechg_upd got %b want 1", update); else passed++;
        cyc;
        checks++; if (update !== 1'b0) $display("FAIL hex_modechg_upd_end got %b want 0", update); else passed++;
        n_end = 24 + int'($urandom_range(0, 2));
        run = 1'b1;
        for (int n = 0; n <= n_end; n++) begin
            cyc;
            exp_upd = (n == 1) || (n > 0 && n % 4 == 0);
            checks++; if (update !== exp_upd) $display("FAIL hex_run_upd n=%0d got %b want %b", n, update, exp_upd); else passed++;
            checks++; if (dispVal !== 16'(n / 4)) $display("FAIL hex_run_disp n=%0d got %h want %h", n, dispVal, 16'(n / 4)); else passed++;
            checks++; if (dpMask !== ((n >= 1) ? 4'b0000 : 4'b1000)) $display("FAIL hex_run_dp n=%0d got %b", n, dpMask); else passed++;
        end
        exp_hex = n_end / 4;
    endtask

    task automatic test_run_pause_resume;
        logic exp_upd;
        run = 1'b0;
        for (int m = 0; m <= 6; m++) begin
            cyc;
            checks++; if (update !== (m == 1)) $display("FAIL drop_upd m=%0d got %b want %b", m, update, (m == 1)); else passed++;
            checks++; if (dispVal !== 16'(exp_hex)) $display("FAIL drop_disp m=%0d got %h want %h", m, dispVal, 16'(exp_hex)); else passed++;
            checks++; if (dpMask !== ((m >= 1) ? 4'b1000 : 4'b0000)) $display("FAIL drop_dp m=%0d got %b", m, dpMask); else passed++;
        end
        run = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            cyc;
            exp_upd = (n == 1) || (n > 0 && n % 4 == 0);
            checks++; if (update !== exp_upd) $display("FAIL resume_upd n=%0d got %b want %b", n, update, exp_upd); else passed++;
            checks++; if (dispVal !== 16'(exp_hex + n / 4)) $display("FAIL resume_disp n=%0d got %h want %h", n, dispVal, 16'(exp_hex + n / 4)); else passed++;
            step = (n < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        exp_hex = exp_hex + 3;
        run = 1'b0;
        cyc;
        cyc;
    endtask

    task automatic test_step_paused;
        int gap;
        for (int i = 0; i < 6; i++) begin
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) begin
                cyc;
                checks++; if (update !== 1'b0) $display("FAIL step_idle_upd got %b want 0", update); else passed++;
            end
            step = 1'b1;
            cyc;
            step = 1'b0;
            exp_hex++;
            checks++; if (update !== 1'b1) $display("FAIL step_upd got %b want 1", update); else passed++;
            checks++; if (dispVal !== 16'(exp_hex)) $display("FAIL step_disp got %h want %h", dispVal, 16'(exp_hex)); else passed++;
        end
    endtask

    task automatic test_hex_wrap;
        int errs = 0;
        mode2 = 2'd1;
        cyc;
        cyc;
        step2 = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            cyc;
            if (dispVal2 !== 8'(i % 256) || update2 !== 1'b1 || dpMask2 !== 2'b10) errs++;
            if (i == 255) begin
                checks++; if (dispVal2 !== 8'hFF) $display("FAIL wrap_ff got %h want ff", dispVal2); else passed++;
            end
            if (i == 256) begin
                checks++; if (dispVal2 !== 8'h00) $display("FAIL wrap_00 got %h want 00", dispVal2); else passed++;
            end
        end
        step2 = 1'b0;
        checks++; if (errs !== 0) $display("FAIL wrap_seq mismatching cycles got %0d want 0", errs); else passed++;
    endtask

    task automatic test_bcd_step;
        int errs = 0;
        logic [15:0] exp_v;
        mode = 2'd2;
        cyc;
        checks++; if (dispVal !== 16'h0000) $display("FAIL bcd_clear got %h want 0000", dispVal); else passed++;
        step = 1'b1;
        for (int i = 1; i <= 10000; i++) begin
            cyc;
            exp_v = dec_model(i);
            if (dispVal !== exp_v || update !== 1'b1) errs++;
            if (i == 10 || i == 100 || i == 10000) begin
                checks++; if (dispVal !== exp_v) $display("FAIL bcd_at_%0d got %h want %h", i, dispVal, exp_v); else passed++;
            end
        end
        step = 1'b0;
        checks++; if (errs !== 0) $display("FAIL bcd_seq mismatching cycles got %0d want 0", errs); else passed++;
    endtask

    task automatic test_shift;
        int gap;
        mode = 2'd0;
        cyc;
        cyc;
        for (int i = 1; i <= 16; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) cyc;
            step = 1'b1;
            cyc;
            step = 1'b0;
            checks++; if (dispVal !== shift_model(i)) $display("FAIL shift_%0d got %h want %h", i, dispVal, shift_model(i)); else passed++;
            checks++; if (update !== 1'b1) $display("FAIL shift_upd_%0d got %b want 1", i, update); else passed++;
            if (i == 16) begin
                checks++; if (dispVal !== 16'h2480) $display("FAIL shift_16 got %h want 2480", dispVal); else passed++;
            end
        end
    endtask

    task automatic test_walk;
        int gap;
        logic [3:0] exp_dp;
        mode = 2'd3;
        cyc;
        checks++; if (dispVal !== 16'h0000) $display("FAIL walk_clear got %h want 0000", dispVal); else passed++;
        checks++; if (dpMask !== 4'b0001) $display("FAIL walk_clear_dp got %b want 0001", dpMask); else passed++;
        cyc;
        for (int i = 1; i <= 7; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) cyc;
            step = 1'b1;
            cyc;
            step = 1'b0;
            exp_dp = 4'(1 << (i % 4));
            checks++; if (dispVal !== walk_model(i)) $display("FAIL walk_%0d got %h want %h", i, dispVal, walk_model(i)); else passed++;
            checks++; if (dpMask !== exp_dp) $display("FAIL walk_dp_%0d got %b want %b", i, dpMask, exp_dp); else passed++;
        end
    endtask

    task automatic test_mode_change_tick;
        mode = 2'd1;
        step = 1'b1;
        cyc;
        step = 1'b0;
        checks++; if (dispVal !== 16'h0000) $display("FAIL mc_tick_disp got %h want 0000", dispVal); else passed++;
        checks++; if (update !== 1'b1) $display("FAIL mc_tick_upd got %b want 1", update); else passed++;
        checks++; if (dpMask !== 4'b1000) $display("FAIL mc_tick_dp got %b want 1000", dpMask); else passed++;
        cyc;
        checks++; if (update !== 1'b0) $display("FAIL mc_tick_single got %b want 0", update); else passed++;
        checks++; if (dispVal !== 16'h0000) $display("FAIL mc_tick_dropped got %h want 0000", dispVal); else passed++;
    endtask

    task automatic test_reset_on_tick;
        run = 1'b1;
        for (int n = 0; n <= 3; n++) cyc;
        reset = 1'b1;
        cyc;
        checks++; if (dispVal !== 16'h0000) $display("FAIL rst_tick_disp got %h want 0000", dispVal); else passed++;
        checks++; if (dpMask !== 4'b1000) $display("FAIL rst_tick_dp got %b want 1000", dpMask); else passed++;
        checks++; if (update !== 1'b0) $display("FAIL rst_tick_upd got %b want 0", update); else passed++;
        run = 1'b0;
        mode = 2'd0;
        reset = 1'b0;
        cyc;
        checks++; if (update !== 1'b0) $display("FAIL rst_release_upd got %b want 0", update); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        mode  = 2'd0;
        run   = 1'b0;
        step  = 1'b0;
        mode2 = 2'd0;
        step2 = 1'b0;
        run2  = 1'b0;
        repeat (3) cyc;
        test_reset;
        reset = 1'b0;
        cyc;
        test_hex_run;
        test_run_pause_resume;
        test_step_paused;
        test_hex_wrap;
        test_bcd_step;
        test_shift;
        test_walk;
        test_mode_change_tick;
        test_reset_on_tick;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
